// File: rtl/instr_decode_pkg.sv
// +----------------------------------------------------------------------+
// | instr_decode_pkg : shared state encoding, opcode and field constants |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package instr_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned DATA_W   = 15;

  // Field positions within the effective (index-adjusted) 15-bit word
  localparam int unsigned PAR_BIT  = 15;
  localparam int unsigned OPC_MSB  = 14;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned QC_MSB   = 11;
  localparam int unsigned QC_LSB   = 10;
  localparam int unsigned ADDR_MSB = 11;
  localparam int unsigned ADDR_LSB = 0;

  localparam logic [2:0] OP_TC     = 3'd0;
  localparam logic [2:0] OP_CCS    = 3'd1;
  localparam logic [2:0] OP_CS     = 3'd4;
  localparam logic [2:0] OP_INDEX  = 3'd5;
  localparam logic [2:0] OP_XCH    = 3'd5;
  localparam logic [2:0] OP_TS     = 3'd5;
  localparam logic [2:0] OP_EXTEND = 3'd5;
  localparam logic [2:0] OP_AD     = 3'd6;
  localparam logic [2:0] OP_MASK   = 3'd7;

  // Quarter-codes that split opcode 5
  localparam logic [1:0] QC_INDEX  = 2'd0;
  localparam logic [1:0] QC_EXTEND = 2'd1;
  localparam logic [1:0] QC_TS     = 2'd2;
  localparam logic [1:0] QC_XCH    = 2'd3;

  // High when the word carries an even number of ones (odd parity violated)
  function automatic logic parity_bad(input logic [WORD_W-1:0] w);
    return ~^w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decode_oc_add15.sv
// +----------------------------------------------------------------------+
// | oc_add15 : combinational 15-bit ones-complement adder                |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module oc_add15
  import instr_decode_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W:0] raw_sum;

  // End-around carry folds back into bit0; one fold suffices since
  // 7FFF + 7FFF = 7FFE carry 1 -> 7FFF never carries again.
  always_comb begin
    raw_sum = {1'b0, a} + {1'b0, b};
    sum     = raw_sum[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, raw_sum[DATA_W]};
  end

endmodule

`default_nettype wire

// File: rtl/instr_decode.sv
// +----------------------------------------------------------------------+
// | instr_decode : fetch / index-adjust / field-decode of one word       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_decode
  import instr_decode_pkg::*;
#(
  parameter bit PARITY_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic        fetch_req,
  input  logic        ext_set,
  input  logic        index_valid,
  input  logic [14:0] index_value,
  input  logic        instr_done,
  output logic [2:0]  opcode,
  output logic [1:0]  qc,
  output logic [11:0] addr,
  output logic        extracode,
  output logic        instr_valid,
  output logic        parity_err
);

  state_e      state_q, state_d;
  logic        do_latch;

  logic [2:0]  opcode_q, opcode_d;
  logic [1:0]  qc_q, qc_d;
  logic [11:0] addr_q, addr_d;
  logic        extracode_q, extracode_d;
  logic        parity_err_q, parity_err_d;
  logic        ext_pending_q, ext_pending_d;
  logic        idx_pending_q, idx_pending_d;
  logic [14:0] index_reg_q, index_reg_d;

  logic [14:0] idx_addend;
  logic [14:0] eff_word;
  logic        word_parity_bad;

  assign idx_addend      = idx_pending_q ? index_reg_q : '0;
  assign word_parity_bad = PARITY_CHECK ? parity_bad(mem_rdata) : 1'b0;

  oc_add15 u_oc_add15 (
    .a   (mem_rdata[DATA_W-1:0]),
    .b   (idx_addend),
    .sum (eff_word)
  );

  always_comb begin
    state_d  = state_q;
    do_latch = 1'b0;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_valid) begin
          state_d  = ST_HOLD;
          do_latch = 1'b1;
        end
      end
      ST_HOLD:  if (instr_done) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A latch consumes the pending flags as they stood before this edge; a
  // coincident ext_set/index_valid therefore applies to the following word.
  always_comb begin
    opcode_d      = opcode_q;
    qc_d          = qc_q;
    addr_d        = addr_q;
    extracode_d   = extracode_q;
    parity_err_d  = parity_err_q;
    ext_pending_d = ext_pending_q;
    idx_pending_d = idx_pending_q;
    index_reg_d   = index_reg_q;

    if (do_latch) begin
      opcode_d      = eff_word[OPC_MSB:OPC_LSB];
      qc_d          = eff_word[QC_MSB:QC_LSB];
      addr_d        = eff_word[ADDR_MSB:ADDR_LSB];
      extracode_d   = ext_pending_q;
      parity_err_d  = word_parity_bad;
      ext_pending_d = 1'b0;
      idx_pending_d = 1'b0;
    end

    if (ext_set) begin
      ext_pending_d = 1'b1;
    end

    if (index_valid) begin
      index_reg_d   = index_value;
      idx_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      qc_q          <= '0;
      addr_q        <= '0;
      extracode_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      ext_pending_q <= 1'b0;
      idx_pending_q <= 1'b0;
      index_reg_q   <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      qc_q          <= qc_d;
      addr_q        <= addr_d;
      extracode_q   <= extracode_d;
      parity_err_q  <= parity_err_d;
      ext_pending_q <= ext_pending_d;
      idx_pending_q <= idx_pending_d;
      index_reg_q   <= index_reg_d;
    end
  end

  assign fetch_req   = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_HOLD);
  assign opcode      = opcode_q;
  assign qc          = qc_q;
  assign addr        = addr_q;
  assign extracode   = extracode_q;
  assign parity_err  = parity_err_q;

endmodule

`default_nettype wire

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 Parameter: PARITY_CHECK, 1, when 1 parity_err is computed; when 0 parity_err is held at 0.
REQ-002 Port: clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low; one clock, no other clock domains.
REQ-004 Port: mem_rdata  in  16  word at PC; bit15 is parity, bits14:0 are data.
REQ-005 Port: mem_valid  in  1  mem_rdata is valid this cycle.
REQ-006 Port: fetch_req  out  1  request for the memory word at PC.
REQ-007 Port: ext_set  in  1  single-cycle pulse from the control sequencer when an EXTEND completes.
REQ-008 Port: index_valid  in  1  single-cycle pulse: index_value applies to the next fetched word.
REQ-009 Port: index_value  in  15  ones-complement index addend.
REQ-010 Port: instr_done  in  1  control sequencer has returned to its load state.
REQ-011 Port: opcode  out  3 / qc  out  2 / addr  out  12 / extracode  out  1  decoded fields, registered.
REQ-012 Port: instr_valid  out  1  decoded fields are stable and may be consumed.
REQ-013 Port: parity_err  out  1  latched word failed odd parity.

Function
REQ-014 FSM states: IDLE, FETCH, HOLD; IDLE -> FETCH unconditionally on the next edge.
REQ-015 FETCH: fetch_req=1 and instr_valid=0; on mem_valid, latch the word and go to HOLD.
REQ-016 HOLD: fetch_req=0 and instr_valid=1; fields stay constant until instr_done=1, then go to FETCH.
REQ-017 instr_done outside HOLD is ignored; mem_valid outside FETCH is ignored.
REQ-018 Latch-to-instr_valid latency is 1 cycle; instr_done-to-fetch_req latency is 1 cycle.
REQ-019 Effective word = ones-complement 15-bit sum of mem_rdata[14:0] and the pending index (0 if none).
REQ-020 The sum's end-around carry is added back into bit0: 7FFF + 0001 = 0001; negative zero 7FFF is kept unchanged.
REQ-021 Decoded fields: opcode=eff[14:12], qc=eff[11:10], addr=eff[11:0].
REQ-022 parity_err = XNOR-reduction of the raw mem_rdata[15:0], before the index add (odd parity required).
REQ-023 ext_pending is set by ext_set; at latch, extracode=ext_pending and ext_pending clears.
REQ-024 If ext_set coincides with a latch, the latched word takes the old pending value, and ext_pending ends at 1.
REQ-025 index_valid loads index_reg and sets idx_pending; at latch, idx_pending clears.
REQ-026 If index_valid coincides with a latch, the latched word uses the old index, and the new index is retained for the following word.
REQ-027 A second index_valid before a latch overwrites index_reg (last wins, no accumulation).

Reset
REQ-028 rst_n low asynchronously forces state=IDLE and clears all of: fetch_req, instr_valid, opcode, qc, addr, extracode, parity_err, ext_pending, idx_pending, index_reg.
REQ-029 Reset asserted mid-FETCH or mid-HOLD discards the in-flight word; after release, the first fetch_req comes 1 cycle after the IDLE->FETCH edge.

Structure
REQ-030 The shared package holds: the FSM state encoding, the opcode constants (TC=0, CCS=1, INDEX/XCH/TS/EXTEND=5 with qc, CS=4, AD=6, MASK=7), and field bit positions.
REQ-031 One sub-module, oc_add15: a combinational 15-bit ones-complement adder with end-around carry.

Verification
REQ-032 Reset release; mem_valid with E005 -> opcode=6, qc=0, addr=005, extracode=0, parity_err=0, instr_valid=1 the next cycle.
REQ-033 Word 6005 (even parity) -> parity_err=1; same word with PARITY_CHECK=0 -> parity_err=0.
REQ-034 ext_set pulse, then E005 -> extracode=1 (SU); next word 9001 -> extracode=0.
REQ-035 index_valid with 0003, then word E005 -> addr=008; index_value 0001 with word FFFF (data 7FFF) -> eff=0001, opcode=0.
REQ-036 ext_set and index_valid on the latch cycle -> current word unaffected; the following word has extracode=1 and the new index applied.
REQ-037 rst_n low during HOLD -> all outputs 0 immediately; instr_done held high during reset has no effect; fetch resumes per REQ-029.
